// File: rtl/add_result_monitor.sv
// Result checker for the 8-bit adder harness: predicts a_i+b_i, compares it with res_i
// LATENCY cycles later, and keeps saturating pass/fail counters plus first-mismatch capture.
module add_result_monitor #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    output logic             chk_valid_o,
    output logic             match_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             err_o,
    output logic [WIDTH-1:0] err_exp_o,
    output logic [WIDTH-1:0] err_got_o,
    output logic             busy_o,
    output logic             done_o
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("add_result_monitor: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]   exp_q [LATENCY];
    logic [WIDTH-1:0]   exp_d [LATENCY];
    logic               chk_q, chk_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   err_exp_q, err_exp_d;
    logic [WIDTH-1:0]   err_got_q, err_got_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        state_d   = state_q;
        chk_d     = 1'b0;
        match_d   = match_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        err_d     = err_q;
        err_exp_d = err_exp_q;
        err_got_d = err_got_q;

        vld_d[0] = in_valid_i && (state_q == RUN) && !stop_i;
        exp_d[0] = a_i + b_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
        end

        if (vld_q[LATENCY-1]) begin
            chk_d   = 1'b1;
            match_d = (exp_q[LATENCY-1] == res_i);
            if (match_d) begin
                if (pass_q != '1) pass_d = pass_q + 1'b1;
            end else begin
                if (fail_q != '1) fail_d = fail_q + 1'b1;
                if (!err_q) begin
                    err_d     = 1'b1;
                    err_exp_d = exp_q[LATENCY-1];
                    err_got_d = res_i;
                end
            end
        end

        // Drain completion looks at the line after this cycle's tail compare and shift.
        unique case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     if (stop_i) state_d = (|vld_d) ? DRAIN : DONE;
            DRAIN:   if (!(|vld_d)) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (start_i) begin
            state_d   = RUN;
            vld_d     = '0;
            chk_d     = 1'b0;
            match_d   = 1'b0;
            pass_d    = '0;
            fail_d    = '0;
            err_d     = 1'b0;
            err_exp_d = '0;
            err_got_d = '0;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            vld_q     <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) exp_q[i] <= '0;
            chk_q     <= 1'b0;
            match_q   <= 1'b0;
            pass_q    <= '0;
            fail_q    <= '0;
            err_q     <= 1'b0;
            err_exp_q <= '0;
            err_got_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= vld_d;
            for (int unsigned i = 0; i < LATENCY; i++) exp_q[i] <= exp_d[i];
            chk_q     <= chk_d;
            match_q   <= match_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            err_exp_q <= err_exp_d;
            err_got_q <= err_got_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign chk_valid_o = chk_q;
    assign match_o     = match_q;
    assign pass_cnt_o  = pass_q;
    assign fail_cnt_o  = fail_q;
    assign err_o       = err_q;
    assign err_exp_o   = err_exp_q;
    assign err_got_o   = err_got_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_add_result_monitor.sv
// Bench for add_result_monitor: three instances (LATENCY 1, LATENCY 4, 4-bit counters)
// fed by one stimulus stream and a stand-in adder with injectable result corruption.
module tb_add_result_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n_b = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [7:0] mask = '0;
    logic [7:0] pipe [4];
    logic [7:0] res1, res4;

    logic        chk_a, match_a, err_a, busy_a, done_a;
    logic [15:0] pass_a, fail_a;
    logic [7:0]  eexp_a, egot_a;
    logic        chk_b, match_b, err_b, busy_b, done_b;
    logic [15:0] pass_b, fail_b;
    logic [7:0]  eexp_b, egot_b;
    logic        chk_c, match_c, err_c, busy_c, done_c;
    logic [3:0]  pass_c, fail_c;
    logic [7:0]  eexp_c, egot_c;

    bit q_a[$];
    bit q_b[$];
    bit q_c[$];
    int n_chk = 0;
    int n_pass = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int base;

    always #5 clk = ~clk;

    // Stand-in adder: result appears one cycle after the operands, optionally corrupted.
    always @(posedge clk) begin
        pipe[0] <= in_valid ? ((a_in + b_in) ^ mask) : 8'h00;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end
    assign res1 = pipe[0];
    assign res4 = pipe[3];

    add_result_monitor #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .stop_i(stop), .in_valid_i(in_valid),
        .a_i(a_in), .b_i(b_in), .res_i(res1), .chk_valid_o(chk_a), .match_o(match_a),
        .pass_cnt_o(pass_a), .fail_cnt_o(fail_a), .err_o(err_a), .err_exp_o(eexp_a),
        .err_got_o(egot_a), .busy_o(busy_a), .done_o(done_a)
    );

    add_result_monitor #(.WIDTH(8), .LATENCY(4), .CNT_W(16)) u_dut_b (
        .clk_i(clk), .reset_ni(rst_n_b), .start_i(start), .stop_i(stop), .in_valid_i(in_valid),
        .a_i(a_in), .b_i(b_in), .res_i(res4), .chk_valid_o(chk_b), .match_o(match_b),
        .pass_cnt_o(pass_b), .fail_cnt_o(fail_b), .err_o(err_b), .err_exp_o(eexp_b),
        .err_got_o(egot_b), .busy_o(busy_b), .done_o(done_b)
    );

    add_result_monitor #(.WIDTH(8), .LATENCY(1), .CNT_W(4)) u_dut_c (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .stop_i(stop), .in_valid_i(in_valid),
        .a_i(a_in), .b_i(b_in), .res_i(res1), .chk_valid_o(chk_c), .match_o(match_c),
        .pass_cnt_o(pass_c), .fail_cnt_o(fail_c), .err_o(err_c), .err_exp_o(eexp_c),
        .err_got_o(egot_c), .busy_o(busy_c), .done_o(done_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic score(input string tag, input logic chk, input logic match, inout bit q[$]);
        if (chk) begin
            if (q.size() == 0) check({tag, "_unexpected_chk"}, chk, 1'b0);
            else check({tag, "_match"}, match, q.pop_front());
        end
    endtask

    // One clock: drive inputs, expect a check if accepted, then score outputs 1ns after the edge.
    task automatic step(input logic st, input logic sp, input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] m, input logic acc);
        start = st; stop = sp; in_valid = v; a_in = a; b_in = b; mask = m;
        if (acc) begin
            q_a.push_back(m == 8'h00);
            q_b.push_back(m == 8'h00);
            q_c.push_back(m == 8'h00);
        end
        @(posedge clk);
        #1;
        score("A", chk_a, match_a, q_a);
        score("B", chk_b, match_b, q_b);
        score("C", chk_c, match_c, q_c);
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset, then operands without start must be ignored.
        idle(3);
        rst_n = 1'b1; rst_n_b = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 8'h01, 8'h00, 1'b0);
        check("idle_chk_valid", {31'b0, chk_a}, 0);
        check("idle_pass", pass_a, 0);
        check("idle_fail", fail_a, 0);
        check("idle_err", {31'b0, err_a}, 0);
        check("idle_busy", {31'b0, busy_a}, 0);
        check("idle_done", {31'b0, done_a}, 0);
        check("idle_pass_b", pass_b, 0);

        // Streaming, all matching.
        base = done_cnt_a;
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'(i), 8'(2 * i), 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(6);
        check("stream_pass", pass_a, 10);
        check("stream_fail", fail_a, 0);
        check("stream_err", {31'b0, err_a}, 0);
        check("stream_done_pulses", done_cnt_a - base, 1);
        check("stream_busy", {31'b0, busy_a}, 0);
        check("stream_pass_b", pass_b, 10);
        check("stream_pass_c", {28'b0, pass_c}, 10);

        // Wrap-around: F0+20 -> 10, then the same pair returned as 11.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hF0, 8'h20, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'hF0, 8'h20, 8'h01, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(6);
        check("wrap_pass", pass_a, 1);
        check("wrap_fail", fail_a, 1);
        check("wrap_err", {31'b0, err_a}, 1);
        check("wrap_err_exp", {24'b0, eexp_a}, 32'h10);
        check("wrap_err_got", {24'b0, egot_a}, 32'h11);

        // First-error capture across three mismatches.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'd2, 8'd3, 8'h03, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'd4, 8'd5, 8'h09, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 8'h07, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(6);
        check("first_fail_cnt", fail_a, 3);
        check("first_pass_cnt", pass_a, 0);
        check("first_err_exp", {24'b0, eexp_a}, 5);
        check("first_err_got", {24'b0, egot_a}, 6);
        check("first_err_exp_b", {24'b0, eexp_b}, 5);
        check("first_err_got_b", {24'b0, egot_b}, 6);

        // Drain with LATENCY=4: done_o visible after edge s+3.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(i + 1), 8'h10, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        check("drain_busy_s", {31'b0, busy_b}, 1);
        idle(1);
        check("drain_done_s1", {31'b0, done_b}, 0);
        idle(1);
        check("drain_done_s2", {31'b0, done_b}, 0);
        check("drain_busy_s2", {31'b0, busy_b}, 1);
        idle(1);
        check("drain_done_s3", {31'b0, done_b}, 1);
        check("drain_busy_s3", {31'b0, busy_b}, 0);
        check("drain_pass_b", pass_b, 3);
        idle(1);
        check("drain_done_s4", {31'b0, done_b}, 0);

        // Same drain aborted by reset.
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(i + 1), 8'h10, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(1);
        rst_n_b = 1'b0;
        q_b.delete();
        base = done_cnt_b;
        idle(1);
        rst_n_b = 1'b1;
        idle(5);
        check("abort_done_pulses", done_cnt_b - base, 0);
        check("abort_pass_b", pass_b, 0);
        check("abort_fail_b", fail_b, 0);
        check("abort_busy_b", {31'b0, busy_b}, 0);

        // Start/stop collision then saturation of the 4-bit counters.
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        check("collide_busy", {31'b0, busy_a}, 1);
        check("collide_done", {31'b0, done_a}, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'(3 * i), 8'(i + 7), 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        idle(6);
        check("sat_pass_c", {28'b0, pass_c}, 15);
        check("sat_fail_c", {28'b0, fail_c}, 0);
        check("sat_pass_a", pass_a, 20);

        check("queue_a_empty", q_a.size(), 0);
        check("queue_b_empty", q_b.size(), 0);
        check("queue_c_empty", q_c.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/add_result_monitor.md
# add_result_monitor

Response-side bench block for the 8-bit adder harness. It samples each operand pair offered to the adder and forms the expected sum. It then compares that sum against the adder result a fixed number of cycles later. It keeps pass/fail counters and captures the first mismatch, so a simulation can be judged without a software scoreboard.

## Interface
- WIDTH, 8: operand and result width.
- LATENCY, 1: clock cycles from an operand pair to its result on res_i. Legal range 1..15; other values are a compile-time error.
- CNT_W, 16: width of the pass/fail counters.
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; clears counters and error capture, then starts a run.
- stop_i  in  1  one-cycle pulse; ends acceptance and drains outstanding checks.
- in_valid_i  in  1  an operand pair is valid this cycle.
- a_i  in  WIDTH  operand A, as driven to the adder.
- b_i  in  WIDTH  operand B, as driven to the adder.
- res_i  in  WIDTH  adder result.
- chk_valid_o  out  1  a comparison completed last cycle.
- match_o  out  1  result of that comparison; meaningful only while chk_valid_o=1.
- pass_cnt_o  out  CNT_W  number of matching checks.
- fail_cnt_o  out  CNT_W  number of mismatching checks.
- err_o  out  1  sticky; a mismatch has occurred in this run.
- err_exp_o  out  WIDTH  expected value of the first mismatch.
- err_got_o  out  WIDTH  observed value of the first mismatch.
- busy_o  out  1  state is RUN or DRAIN.
- done_o  out  1  one-cycle pulse when a drain completes.

## Operation
- Expected value = (a_i + b_i) mod 2^WIDTH. The carry is discarded.
- The monitor holds a LATENCY-deep delay line of {valid, expected}. The delay line shifts every cycle. A slot enters with valid=1 only when in_valid_i=1 and state=RUN.
- When a valid slot reaches the tail, the monitor compares it with res_i in that cycle:
  - On a match, pass_cnt increments.
  - On a mismatch, fail_cnt increments. If err_o=0, err_o sets and the monitor captures err_exp_o/err_got_o.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_valid_i is ignored. start_i moves to RUN.
  - RUN: operands are accepted. stop_i moves to DRAIN.
  - DRAIN: in_valid_i is ignored. The monitor moves to DONE when no valid slot remains in the delay line, checking that condition after the tail compare of the current cycle. done_o=1 on the cycle after the transition into DONE.
  - DONE: outputs hold. start_i moves to RUN.
- start_i in any state clears pass_cnt, fail_cnt, err_o, err_exp_o, err_got_o and the delay line, then enters RUN. Comparisons that were pending when start_i arrived are discarded and not counted.
- If start_i and stop_i arrive in the same cycle, start_i wins and the next state is RUN.
- stop_i outside RUN is ignored.
- in_valid_i on the start_i cycle is discarded, because the delay line is being cleared.

## Timing
- All outputs are registered.
- Reset values: chk_valid_o=0, match_o=0, pass_cnt_o=0, fail_cnt_o=0, err_o=0, err_exp_o=0, err_got_o=0, busy_o=0, done_o=0, state=IDLE, delay line all invalid.
- Asserting reset_ni=0 at any point, including mid-run or mid-drain, forces the reset values immediately. No outstanding check survives.
- Operand pair at edge n is compared against res_i sampled at edge n+LATENCY. chk_valid_o, match_o and the counters update at that edge, becoming visible after edge n+LATENCY.
- Back-to-back in_valid_i gives one check per cycle, with no bubbles.
- stop_i at edge s: the last accepted pair is the one at edge s-1. The state enters DONE at edge s+LATENCY-1, or earlier if the delay line is already empty. done_o is high for exactly one cycle after that edge.
- busy_o reflects the registered state.

## Test plan
- Reset then idle: hold reset_ni=0 for 3 cycles, release, drive in_valid_i=1 with no start_i -> all outputs 0 and counters stay 0.
- Streaming pass, LATENCY=1: start_i, then 10 back-to-back pairs (a=i, b=2i) with res_i driven correctly one cycle later, then stop_i -> pass_cnt_o=10, fail_cnt_o=0, err_o=0, done_o pulses once.
- Wrap-around: pair a=8'hF0, b=8'h20 with res_i=8'h10 -> match_o=1 and pass_cnt increments. The same pair with res_i=8'h11 -> fail_cnt=1, err_exp_o=8'h10, err_got_o=8'h11.
- First-error capture: three mismatches, (exp 5/got 6), (exp 9/got 0), (exp 3/got 4) -> fail_cnt_o=3, err_exp_o=5, err_got_o=6.
- Drain and abort, LATENCY=4: send 3 pairs, then stop_i -> the 3 checks complete and done_o fires at the stated edge. Repeat, asserting reset_ni=0 mid-drain -> done_o never fires and counters are 0.
- Start/stop collision and saturation, CNT_W=4: start_i and stop_i together -> state RUN. Then 20 matching pairs -> pass_cnt_o stays at 15.
